// File: rtl/dpi_stream_sequencer_pkg.sv
// Shared defaults and FSM encoding for the DPI stream sequencer and its flow table.
package dpi_seq_pkg;

  localparam int DEF_KEY_W       = 32;
  localparam int DEF_SID_W       = 6;
  localparam int DEF_NUM_STREAMS = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_LOAD,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_EOP
  } state_e;

endpackage

// File: rtl/dpi_stream_sequencer_flow_table.sv
// Flow key -> stream id table: parallel compare, lowest-free allocation and
// round-robin victim replacement once every entry is valid.
module dpi_flow_table
  import dpi_seq_pkg::*;
#(
  parameter int KEY_W       = DEF_KEY_W,
  parameter int NUM_STREAMS = DEF_NUM_STREAMS,
  parameter int SID_W       = DEF_SID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [KEY_W-1:0] lookup_key,
  output logic             hit,
  output logic [SID_W-1:0] idx,
  input  logic             alloc,
  input  logic [SID_W-1:0] alloc_idx,
  input  logic [KEY_W-1:0] alloc_key
);

  logic [NUM_STREAMS-1:0] vld_q, vld_d;
  logic [KEY_W-1:0]       key_q [NUM_STREAMS];
  logic [SID_W-1:0]       victim_q, victim_d;
  logic [SID_W-1:0]       hit_idx, free_idx;
  logic                   any_free;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (vld_q[i] && (key_q[i] == lookup_key)) begin
        hit     = 1'b1;
        hit_idx = SID_W'(i);
      end
      if (!vld_q[i]) begin
        any_free = 1'b1;
        free_idx = SID_W'(i);
      end
    end
    idx = hit ? hit_idx : (any_free ? free_idx : victim_q);
  end

  always_comb begin
    vld_d    = vld_q;
    victim_d = victim_q;
    if (clear) begin
      vld_d    = '0;
      victim_d = '0;
    end else if (alloc) begin
      if (&vld_q) victim_d = victim_q + SID_W'(1);
      vld_d[alloc_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      victim_q <= '0;
    end else begin
      vld_q    <= vld_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc && !clear) key_q[alloc_idx] <= alloc_key;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet-to-matcher sequencer: resolves the flow key to a stream id, then emits
// load_state, the byte stream and a closing eop pulse for the regex matchers.
module dpi_stream_sequencer
  import dpi_seq_pkg::*;
#(
  parameter int KEY_W       = DEF_KEY_W,
  parameter int NUM_STREAMS = DEF_NUM_STREAMS,
  parameter int SID_W       = DEF_SID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pkt_data,
  input  logic             pkt_vld,
  input  logic             pkt_sop,
  input  logic             pkt_eop,
  input  logic [KEY_W-1:0] pkt_key,
  output logic             pkt_rdy,
  input  logic             cfg_we,
  input  logic [SID_W-1:0] cfg_sid,
  input  logic             cfg_en,
  input  logic             cfg_clear,
  output logic             load_state,
  output logic [SID_W-1:0] stream_id,
  output logic             new_stream_id,
  output logic             enable,
  output logic [7:0]       char_in,
  output logic             char_in_vld,
  output logic             eop,
  output logic [15:0]      err_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e                 state_q, state_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic [SID_W-1:0]       sid_q, sid_d;
  logic                   new_q, new_d, en_q, en_d, load_q, load_d;
  logic [7:0]             chr_q, chr_d;
  logic                   cvld_q, cvld_d, eop_q, eop_d;
  logic [15:0]            err_q, err_d;
  logic                   clr_pend_q, clr_pend_d, first_q, first_d;
  logic [NUM_STREAMS-1:0] en_map_q, en_map_d;
  logic                   rdy_c, err_inc, tbl_clear, tbl_alloc, tbl_hit;
  logic [SID_W-1:0]       tbl_idx;

  dpi_flow_table #(.KEY_W(KEY_W), .NUM_STREAMS(NUM_STREAMS), .SID_W(SID_W)) u_table (
    .clk       (clk),
    .rst       (rst),
    .clear     (tbl_clear),
    .lookup_key(key_q),
    .hit       (tbl_hit),
    .idx       (tbl_idx),
    .alloc     (tbl_alloc),
    .alloc_idx (sid_q),
    .alloc_key (key_q)
  );

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    sid_d      = sid_q;
    new_d      = new_q;
    en_d       = en_q;
    load_d     = 1'b0;
    chr_d      = chr_q;
    cvld_d     = 1'b0;
    eop_d      = 1'b0;
    first_d    = first_q;
    clr_pend_d = clr_pend_q | cfg_clear;
    rdy_c      = 1'b0;
    err_inc    = 1'b0;
    tbl_clear  = 1'b0;
    tbl_alloc  = 1'b0;
    en_map_d   = en_map_q;
    if (cfg_we) en_map_d[cfg_sid] = cfg_en;
    unique case (state_q)
      S_IDLE: begin
        rdy_c      = pkt_vld & ~pkt_sop;
        err_inc    = pkt_vld & ~pkt_sop;
        // A clear landing with an sop wipes the table before the lookup sees it.
        tbl_clear  = cfg_clear | clr_pend_q;
        clr_pend_d = 1'b0;
        if (pkt_vld && pkt_sop) begin
          key_d   = pkt_key;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        sid_d   = tbl_idx;
        new_d   = ~tbl_hit;
        en_d    = en_map_q[tbl_idx];
        load_d  = 1'b1;
        first_d = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        tbl_alloc = new_q;
        state_d   = S_PRIME;
      end
      S_PRIME: state_d = S_STREAM;
      S_STREAM: begin
        rdy_c = 1'b1;
        if (pkt_vld) begin
          chr_d   = pkt_data;
          cvld_d  = 1'b1;
          // The held sop byte opening the packet is legitimate; later sops are not.
          err_inc = pkt_sop & ~first_q;
          first_d = 1'b0;
          if (pkt_eop) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        eop_d   = 1'b1;
        state_d = S_EOP;
      end
      S_EOP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    err_d = err_inc ? sat_inc16(err_q) : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sid_q      <= '0;
      new_q      <= 1'b0;
      en_q       <= 1'b0;
      load_q     <= 1'b0;
      chr_q      <= '0;
      cvld_q     <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= '0;
      clr_pend_q <= 1'b0;
      first_q    <= 1'b0;
      en_map_q   <= '0;
    end else begin
      state_q    <= state_d;
      sid_q      <= sid_d;
      new_q      <= new_d;
      en_q       <= en_d;
      load_q     <= load_d;
      chr_q      <= chr_d;
      cvld_q     <= cvld_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      clr_pend_q <= clr_pend_d;
      first_q    <= first_d;
      en_map_q   <= en_map_d;
    end
  end

  always_ff @(posedge clk) key_q <= key_d;

  assign pkt_rdy       = rdy_c & ~rst;
  assign load_state    = load_q;
  assign stream_id     = sid_q;
  assign new_stream_id = new_q;
  assign enable        = en_q;
  assign char_in       = chr_q;
  assign char_in_vld   = cvld_q;
  assign eop           = eop_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Bench for dpi_stream_sequencer: vector table of packets plus hand-built
// sequences, checked against header/char scoreboard queues.
module tb_dpi_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst, pkt_vld, pkt_sop, pkt_eop, pkt_rdy;
  logic [7:0]  pkt_data;
  logic [31:0] pkt_key;
  logic        cfg_we, cfg_en, cfg_clear;
  logic [5:0]  cfg_sid;
  logic        load_state, new_stream_id, enable, char_in_vld, eop;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic [15:0] err_cnt;

  dpi_stream_sequencer dut (
    .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_key(pkt_key), .pkt_rdy(pkt_rdy), .cfg_we(cfg_we),
    .cfg_sid(cfg_sid), .cfg_en(cfg_en), .cfg_clear(cfg_clear), .load_state(load_state),
    .stream_id(stream_id), .new_stream_id(new_stream_id), .enable(enable),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] key;
    int          len;
    logic [7:0]  base;
    logic [5:0]  sid;
    logic        nw;
    logic        en;
  } vec_t;

  int          n_cmp = 0, n_fail = 0, cyc = 0, eop_cnt = 0;
  int          load_cyc = 0, last_cyc = 0;
  logic        open = 1'b0, first = 1'b0;
  logic [7:0]  hdr_q [$];
  logic [7:0]  chr_q [$];
  logic [7:0]  cur = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: headers and chars are popped from the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      open  = 1'b0;
      first = 1'b0;
    end else begin
      if (load_state) begin
        if (hdr_q.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
        else begin
          cur = hdr_q.pop_front();
          chk("stream_id", 32'(stream_id), 32'(cur[7:2]));
          chk("new_stream_id", 32'(new_stream_id), 32'(cur[1]));
          chk("enable", 32'(enable), 32'(cur[0]));
        end
        open = 1'b1; first = 1'b1; load_cyc = cyc;
      end
      if (char_in_vld) begin
        if (first) chk("prime_gap", 32'(cyc - load_cyc), 32'd3);
        first = 1'b0;
        if (chr_q.size() == 0) chk("char_unexpected", 32'd1, 32'd0);
        else chk("char_in", 32'(char_in), 32'(chr_q.pop_front()));
        last_cyc = cyc;
      end
      if (eop) begin
        chk("eop_in_packet", 32'(open), 32'd1);
        chk("eop_gap", 32'(cyc - last_cyc), 32'd1);
        chk("hold_sid", 32'(stream_id), 32'(cur[7:2]));
        chk("hold_new", 32'(new_stream_id), 32'(cur[1]));
        chk("hold_en", 32'(enable), 32'(cur[0]));
        open = 1'b0;
        eop_cnt++;
      end
    end
  end

  task automatic send_pkt(input logic [31:0] key, input int len, input logic [7:0] base,
                          input logic [5:0] esid, input logic enew, input logic een,
                          input int sop_at);
    int n;
    int e0;
    e0 = eop_cnt;
    @(posedge clk); #1;
    hdr_q.push_back({esid, enew, een});
    pkt_key = key;
    for (int i = 0; i < len; i++) begin
      pkt_vld  = 1'b1;
      pkt_sop  = (i == 0) || (i == sop_at);
      pkt_eop  = (i == len - 1);
      pkt_data = base + 8'(i);
      n = 0;
      while (!pkt_rdy && n < 20) begin @(posedge clk); #1; n++; end
      chk("rdy_timeout", 32'(pkt_rdy), 32'd1);
      chr_q.push_back(pkt_data);
      @(posedge clk); #1;
    end
    pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    n = 0;
    while (eop_cnt == e0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("single_eop", 32'(eop_cnt - e0), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_load"}, 32'(load_state), 32'd0);
    chk({tag, "_sid"}, 32'(stream_id), 32'd0);
    chk({tag, "_new"}, 32'(new_stream_id), 32'd0);
    chk({tag, "_en"}, 32'(enable), 32'd0);
    chk({tag, "_char"}, 32'(char_in), 32'd0);
    chk({tag, "_cvld"}, 32'(char_in_vld), 32'd0);
    chk({tag, "_eop"}, 32'(eop), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_rdy"}, 32'(pkt_rdy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    int   n;
    int   e0;
    vt[0] = '{32'hA5A5_0001, 3, 8'h41, 6'd0, 1'b1, 1'b0};
    vt[1] = '{32'hA5A5_0001, 2, 8'h50, 6'd0, 1'b0, 1'b0};
    vt[2] = '{32'h0000_00B0, 1, 8'h60, 6'd1, 1'b1, 1'b0};
    vt[3] = '{32'h0000_2000, 2, 8'h70, 6'd0, 1'b1, 1'b0};
    vt[4] = '{32'h0000_2001, 2, 8'h74, 6'd1, 1'b1, 1'b0};
    vt[5] = '{32'hA5A5_0001, 2, 8'h78, 6'd2, 1'b1, 1'b0};

    rst = 1'b1; pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = '0; pkt_key = '0;
    cfg_we = 1'b0; cfg_sid = '0; cfg_en = 1'b0; cfg_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 3; i++)
      send_pkt(vt[i].key, vt[i].len, vt[i].base, vt[i].sid, vt[i].nw, vt[i].en, -1);
    for (int i = 2; i < 64; i++)
      send_pkt(32'h1000 + 32'(i), 1, 8'(i), 6'(i), 1'b1, 1'b0, -1);
    for (int i = 3; i < 6; i++)
      send_pkt(vt[i].key, vt[i].len, vt[i].base, vt[i].sid, vt[i].nw, vt[i].en, -1);

    // Enable written mid-packet only shows up at the next packet's LOAD.
    fork
      send_pkt(32'h2001, 8, 8'h80, 6'd1, 1'b0, 1'b0, -1);
      begin
        repeat (7) @(posedge clk);
        #1; cfg_we = 1'b1; cfg_sid = 6'd1; cfg_en = 1'b1;
        @(posedge clk); #1; cfg_we = 1'b0;
      end
    join
    send_pkt(32'h2001, 2, 8'h88, 6'd1, 1'b0, 1'b1, -1);

    // Three stray bytes in IDLE plus one sop inside a packet.
    @(posedge clk); #1;
    pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_data = 8'hEE;
    repeat (3) @(posedge clk);
    #1; pkt_vld = 1'b0;
    e0 = eop_cnt;
    send_pkt(32'h2000, 4, 8'hA0, 6'd0, 1'b0, 1'b0, 1);
    chk("err_cnt", 32'(err_cnt), 32'd4);
    chk("err_pkt_eops", 32'(eop_cnt - e0), 32'd1);

    // Reset in the middle of STREAM: no eop, everything back to zero.
    @(posedge clk); #1;
    hdr_q.push_back({6'd3, 1'b1, 1'b0});
    pkt_key = 32'h3000; pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_data = 8'hB0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!pkt_rdy && n < 20) begin @(posedge clk); #1; n++; end
      chk("rst_rdy", 32'(pkt_rdy), 32'd1);
      chr_q.push_back(pkt_data);
      @(posedge clk); #1;
      pkt_sop = 1'b0; pkt_data = pkt_data + 8'd1;
    end
    pkt_vld = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    e0 = eop_cnt;
    @(posedge clk); #1;
    check_zero("midrst");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_eop_after_rst", 32'(eop_cnt - e0), 32'd0);

    // Table and bitmap are empty after reset; then a pending clear.
    send_pkt(32'hC0, 2, 8'hC0, 6'd0, 1'b1, 1'b0, -1);
    send_pkt(32'hC1, 2, 8'hC4, 6'd1, 1'b1, 1'b0, -1);
    fork
      send_pkt(32'hC0, 6, 8'hC8, 6'd0, 1'b0, 1'b0, -1);
      begin
        repeat (6) @(posedge clk);
        #1; cfg_clear = 1'b1;
        @(posedge clk); #1; cfg_clear = 1'b0;
      end
    join
    send_pkt(32'hC1, 2, 8'hD0, 6'd0, 1'b1, 1'b0, -1);
    // Clear in the same cycle as the sop: the lookup must miss.
    fork
      send_pkt(32'hC1, 1, 8'hD8, 6'd0, 1'b1, 1'b0, -1);
      begin
        @(posedge clk); #1; cfg_clear = 1'b1;
        @(posedge clk); #1; cfg_clear = 1'b0;
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("hdr_queue_empty", 32'(hdr_q.size()), 32'd0);
    chk("chr_queue_empty", 32'(chr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
